carregador_programa: RTL
========================

Name: carregador_programa

Overview:
Writer side of the processor's instruction-memory read path. It receives a program as a byte stream from a UART receiver and assembles little-endian 32-bit instructions. It writes them sequentially into the instruction memory write port and holds the processor in reset until a complete, checksum-verified image is loaded. It sits beside the processor top level, between the serial receiver and instruction memory.

Parameters:
BASE_ADDR, 32'h0000_0000, byte address of the first instruction written
MAX_WORDS, 256, maximum accepted word count; larger headers are rejected
TIMEOUT_CICLOS, 100000, maximum idle cycles allowed between bytes once loading has started

Ports:
clock  input  1  system clock; all logic on the rising edge
reset  input  1  synchronous, active-low reset
start  input  1  one-cycle pulse that arms a new load; honoured only in OCIOSO, CONCLUIDO or ERRO
byte_valido  input  1  one-cycle strobe; byte_dado is valid in the same cycle
byte_dado  input  8  received byte
escrita_instr  output  1  one-cycle write enable to instruction memory
endereco_escrita  output  32  byte address for the write
instrucao_escrita  output  32  assembled instruction
cpu_reset_n  output  1  active-low reset driven to the processor
carregando  output  1  high from the accepted start until CONCLUIDO or ERRO
concluido  output  1  high in CONCLUIDO
erro  output  1  high in ERRO
palavras_carregadas  output  16  number of words written so far in this load

Behaviour:
- Reset (reset=0 at a clock edge):
  - state=OCIOSO; escrita_instr=0; endereco_escrita=BASE_ADDR; instrucao_escrita=0.
  - cpu_reset_n=0; carregando=0; concluido=0; erro=0; palavras_carregadas=0.
  - Byte, checksum and timeout counters are cleared.
  - Reset in the middle of a load aborts it; no write pulse is produced on that edge or afterwards.
- Frame format: CNT_LO, CNT_HI (16-bit word count N, little-endian), then 4*N data bytes (each word LSB first), then CHK.
  - CHK is the XOR of every preceding byte in the frame, count bytes included.
- State machine:
  - OCIOSO: start -> CONT_LO, and clear the counters and checksum. Bytes received without start are ignored.
  - CONT_LO: on a byte, latch the low count byte -> CONT_HI.
  - CONT_HI: on a byte, form N.
    - N > MAX_WORDS -> ERRO.
    - N = 0 -> CHECKSUM.
    - Otherwise -> DADOS.
  - DADOS: each byte fills lane k (k = 0..3, byte k goes to bits 8k+7:8k).
    - On the edge that accepts lane 3: instrucao_escrita is loaded with the assembled word and endereco_escrita = BASE_ADDR + 4*palavras_carregadas.
    - escrita_instr is high for exactly the next cycle, then palavras_carregadas increments.
    - When the Nth word has been written -> CHECKSUM.
  - CHECKSUM: on a byte, match -> CONCLUIDO, mismatch -> ERRO.
  - CONCLUIDO: concluido=1 and cpu_reset_n=1 (the processor runs). start -> CONT_LO, which drops cpu_reset_n to 0 on the same edge.
  - ERRO: erro=1 and cpu_reset_n=0. start -> CONT_LO.
- Timeout:
  - In CONT_LO, CONT_HI, DADOS and CHECKSUM, a counter increments on every cycle without byte_valido and clears on each byte.
  - When it reaches TIMEOUT_CICLOS -> ERRO, and a partially assembled word is discarded.
- A start pulse while carregando=1 is ignored.
- When start and byte_valido coincide in OCIOSO, CONCLUIDO or ERRO, the byte is discarded. Frames begin with the first byte after start.
- Arithmetic:
  - The address advances by 4 and stays 32 bits wide.
  - palavras_carregadas never exceeds MAX_WORDS.
  - Back-to-back bytes (byte_valido high on consecutive cycles) must be accepted with no loss. The write pulse never stalls input.

Decomposition:
- Package carregador_pkg:
  - State enum: OCIOSO, CONT_LO, CONT_HI, DADOS, CHECKSUM, CONCLUIDO, ERRO.
  - Frame constants: BYTES_POR_PALAVRA=4, LARGURA_CONTAGEM=16.
- One sub-module, montador_palavra:
  - Holds the 2-bit lane counter, the 32-bit shift/lane register and the running XOR.
  - Outputs palavra_pronta and palavra.
  - Has a clear input driven by the FSM on start or timeout.

Test Plan:
1. Reset, start, then bytes 01 00 93 00 50 00 C2: one escrita_instr pulse with endereco_escrita=0x0, instrucao_escrita=0x00500093, palavras_carregadas=1; CONCLUIDO, cpu_reset_n=1.
2. Same frame with CHK=C3: the word is still written, then erro=1, cpu_reset_n=0, concluido=0.
3. Header 01 02 (N=513 > 256): ERRO immediately after CNT_HI, and no escrita_instr pulse occurs.
4. Start, then 02 00 and five data bytes, then idle for TIMEOUT_CICLOS cycles: exactly one write at 0x0, then ERRO. A second start followed by a valid frame succeeds, with the new writes starting at BASE_ADDR.
5. Reset asserted two bytes into a word of a three-word frame: all outputs return to their reset values and no further write occurs. Start plus a fresh frame then loads correctly.
6. Header 00 00 with CHK=00: CONCLUIDO with no writes. Start pulses injected during a loading frame are ignored, and the frame completes normally.

Source files
------------

// File: rtl/carregador_pkg.sv
// Shared definitions for the program loader: FSM states and frame layout constants.
package carregador_pkg;

  typedef enum logic [2:0] {
    OCIOSO,
    CONT_LO,
    CONT_HI,
    DADOS,
    CHECKSUM,
    CONCLUIDO,
    ERRO
  } estado_t;

  localparam int unsigned BYTES_POR_PALAVRA = 4;
  localparam int unsigned LARGURA_CONTAGEM  = 16;

endpackage

// File: rtl/montador_palavra.sv
// Assembles little-endian words from a byte stream and keeps the running frame XOR.
module montador_palavra
  import carregador_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        limpar_i,
  input  logic        soma_en_i,
  input  logic        lane_en_i,
  input  logic [7:0]  byte_i,
  output logic        palavra_pronta_o,
  output logic [31:0] palavra_o,
  output logic [7:0]  soma_o
);

  logic [1:0]  lane_q,  lane_d;
  logic [31:0] lanes_q, lanes_d;
  logic [7:0]  soma_q,  soma_d;

  always_comb begin
    lane_d  = lane_q;
    lanes_d = lanes_q;
    soma_d  = soma_q;
    if (limpar_i) begin
      lane_d  = '0;
      lanes_d = '0;
      soma_d  = '0;
    end else begin
      if (soma_en_i) soma_d = soma_q ^ byte_i;
      if (lane_en_i) begin
        lanes_d[{lane_q, 3'b000} +: 8] = byte_i;
        lane_d                         = lane_q + 2'd1;
      end
    end
  end

  // The completed word includes the byte arriving this cycle, so it is taken from the next-state value.
  assign palavra_pronta_o = lane_en_i && (lane_q == 2'(BYTES_POR_PALAVRA - 1));
  assign palavra_o        = lanes_d;
  assign soma_o           = soma_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      lane_q  <= '0;
      lanes_q <= '0;
      soma_q  <= '0;
    end else begin
      lane_q  <= lane_d;
      lanes_q <= lanes_d;
      soma_q  <= soma_d;
    end
  end

endmodule

// File: rtl/carregador_programa.sv
// Program loader: receives a checksummed byte frame, writes instruction memory and
// keeps the processor in reset until a verified image is present.
module carregador_programa
  import carregador_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter int unsigned MAX_WORDS      = 256,
  parameter int unsigned TIMEOUT_CICLOS = 100000
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        byte_valido,
  input  logic [7:0]                  byte_dado,
  output logic                        escrita_instr,
  output logic [31:0]                 endereco_escrita,
  output logic [31:0]                 instrucao_escrita,
  output logic                        cpu_reset_n,
  output logic                        carregando,
  output logic                        concluido,
  output logic                        erro,
  output logic [LARGURA_CONTAGEM-1:0] palavras_carregadas
);

  localparam int unsigned TW = $clog2(TIMEOUT_CICLOS + 1);

  estado_t                     estado_q,   estado_d;
  logic [7:0]                  cont_lo_q,  cont_lo_d;
  logic [LARGURA_CONTAGEM-1:0] n_q,        n_d;
  logic [LARGURA_CONTAGEM-1:0] palavras_q, palavras_d;
  logic                        escrita_q,  escrita_d;
  logic [31:0]                 end_q,      end_d;
  logic [31:0]                 instr_q,    instr_d;
  logic [TW-1:0]               tmo_q,      tmo_d;

  logic                        limpar, soma_en, lane_en;
  logic                        palavra_pronta;
  logic [31:0]                 palavra;
  logic [7:0]                  soma;
  logic                        ativo;
  logic [LARGURA_CONTAGEM-1:0] n_novo;

  montador_palavra u_montador (
    .clk_i            (clock),
    .rst_ni           (reset),
    .limpar_i         (limpar),
    .soma_en_i        (soma_en),
    .lane_en_i        (lane_en),
    .byte_i           (byte_dado),
    .palavra_pronta_o (palavra_pronta),
    .palavra_o        (palavra),
    .soma_o           (soma)
  );

  assign ativo  = (estado_q == CONT_LO) || (estado_q == CONT_HI) ||
                  (estado_q == DADOS)   || (estado_q == CHECKSUM);
  assign n_novo = {byte_dado, cont_lo_q};

  always_comb begin
    estado_d   = estado_q;
    cont_lo_d  = cont_lo_q;
    n_d        = n_q;
    palavras_d = palavras_q;
    escrita_d  = 1'b0;
    end_d      = end_q;
    instr_d    = instr_q;
    tmo_d      = tmo_q;
    limpar     = 1'b0;
    soma_en    = 1'b0;
    lane_en    = 1'b0;

    if (escrita_q) palavras_d = palavras_q + 1'b1;

    if (ativo) tmo_d = byte_valido ? '0 : tmo_q + 1'b1;

    case (estado_q)
      OCIOSO, CONCLUIDO, ERRO: begin
        if (start) begin
          estado_d   = CONT_LO;
          limpar     = 1'b1;
          tmo_d      = '0;
          palavras_d = '0;
        end
      end
      CONT_LO: begin
        if (byte_valido) begin
          soma_en   = 1'b1;
          cont_lo_d = byte_dado;
          estado_d  = CONT_HI;
        end
      end
      CONT_HI: begin
        if (byte_valido) begin
          soma_en = 1'b1;
          n_d     = n_novo;
          if (32'(n_novo) > MAX_WORDS) estado_d = ERRO;
          else if (n_novo == '0)       estado_d = CHECKSUM;
          else                         estado_d = DADOS;
        end
      end
      DADOS: begin
        if (byte_valido) begin
          soma_en = 1'b1;
          lane_en = 1'b1;
          if (palavra_pronta) begin
            instr_d   = palavra;
            end_d     = BASE_ADDR + {14'd0, palavras_q, 2'b00};
            escrita_d = 1'b1;
            // Leave DADOS on the last lane so a back-to-back CHK byte is not lost.
            if (palavras_q + 1'b1 == n_q) estado_d = CHECKSUM;
          end
        end
      end
      CHECKSUM: begin
        if (byte_valido) estado_d = (byte_dado == soma) ? CONCLUIDO : ERRO;
      end
      default: estado_d = OCIOSO;
    endcase

    if (ativo && !byte_valido && (tmo_q == TW'(TIMEOUT_CICLOS - 1))) begin
      estado_d = ERRO;
      limpar   = 1'b1;
      tmo_d    = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      estado_q   <= OCIOSO;
      cont_lo_q  <= '0;
      n_q        <= '0;
      palavras_q <= '0;
      escrita_q  <= 1'b0;
      end_q      <= BASE_ADDR;
      instr_q    <= '0;
      tmo_q      <= '0;
    end else begin
      estado_q   <= estado_d;
      cont_lo_q  <= cont_lo_d;
      n_q        <= n_d;
      palavras_q <= palavras_d;
      escrita_q  <= escrita_d;
      end_q      <= end_d;
      instr_q    <= instr_d;
      tmo_q      <= tmo_d;
    end
  end

  assign escrita_instr       = escrita_q;
  assign endereco_escrita    = end_q;
  assign instrucao_escrita   = instr_q;
  assign palavras_carregadas = palavras_q;
  assign carregando          = ativo;
  assign concluido           = (estado_q == CONCLUIDO);
  assign erro                = (estado_q == ERRO);
  assign cpu_reset_n         = (estado_q == CONCLUIDO);

endmodule
